ssm_demux_sched: RTL and testbench

SSM_DEMUX_SCHED -- requirements
Module: ssm_demux_sched

---
 rtl/vdcm_ssm_pkg.sv | 27 ++
 rtl/ssm_word_fifo.sv | 82 ++++++++
 rtl/ssm_demux_sched.sv | 155 +++++++++++++++
 tb/tb_ssm_demux_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vdcm_ssm_pkg.sv
// rtl/vdcm_ssm_pkg.sv - shared types, defaults and width helpers for the substream demux
package vdcm_ssm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } ssm_state_e;

  localparam int DEF_NUM_SSM   = 4;
  localparam int DEF_WORD_W    = 128;
  localparam int DEF_BUF_DEPTH = 2;

  // Occupancy counter must be able to hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssm_word_fifo.sv
// rtl/ssm_word_fifo.sv - show-ahead per-substream word buffer with flush
module ssm_word_fifo
  import vdcm_ssm_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WORD_W-1:0]         push_data,
  input  logic                      pop,
  output logic [WORD_W-1:0]         head,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;
  logic              push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != '0);
    // A full buffer still takes a word when its head leaves in the same cycle.
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ssm_demux_sched.sv
// rtl/ssm_demux_sched.sv - distributes mux words from the rate buffer to substream parsers
module ssm_demux_sched
  import vdcm_ssm_pkg::*;
#(
  parameter int NUM_SSM   = DEF_NUM_SSM,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start_dec,
  input  logic                      in_valid,
  input  logic [WORD_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic [NUM_SSM-1:0]        ssm_rd_en,
  output logic [NUM_SSM*WORD_W-1:0] ssm_data,
  output logic [NUM_SSM-1:0]        ssm_empty,
  output logic                      ssm_go,
  output logic                      underflow_err
);

  localparam int CNT_W = cnt_w(BUF_DEPTH);
  localparam int IDX_W = idx_w(NUM_SSM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SSM - 1);

  ssm_state_e         state_q, state_d;
  logic [IDX_W-1:0]   prime_cnt_q, prime_cnt_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               underflow_q, underflow_d;
  logic               ssm_go_q, ssm_go_d;

  logic [CNT_W-1:0]   cnt [NUM_SSM];
  logic [NUM_SSM-1:0] empty_v;
  logic [NUM_SSM-1:0] pop_v;
  logic [NUM_SSM-1:0] push_v;
  logic [NUM_SSM-1:0] elig_v;
  logic               active;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   target;
  logic               transfer;

  // Pops only reach the buffers while a slice is live; IDLE ignores them.
  assign active = start_dec && (state_q != ST_IDLE);
  assign pop_v  = active ? ssm_rd_en : '0;

  always_comb begin
    int idx;
    idx      = 0;
    elig_v   = '0;
    rr_found = 1'b0;
    rr_idx   = last_grant_q;
    for (int k = 0; k < NUM_SSM; k++) begin
      elig_v[k] = (cnt[k] < CNT_W'(BUF_DEPTH)) || pop_v[k];
    end
    for (int i = 1; i <= NUM_SSM; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_SSM;
      if (!rr_found && elig_v[idx]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_PRIME: in_ready = start_dec;
      ST_RUN:   in_ready = start_dec && rr_found;
      default:  in_ready = 1'b0;
    endcase
    target   = (state_q == ST_PRIME) ? prime_cnt_q : rr_idx;
    transfer = in_valid && in_ready;
    push_v   = '0;
    for (int k = 0; k < NUM_SSM; k++) begin
      push_v[k] = transfer && (target == IDX_W'(k));
    end
  end

  always_comb begin
    state_d      = state_q;
    prime_cnt_d  = prime_cnt_q;
    last_grant_d = last_grant_q;
    underflow_d  = underflow_q | (|(pop_v & empty_v));
    if (!start_dec) begin
      state_d      = ST_IDLE;
      prime_cnt_d  = '0;
      last_grant_d = LAST_IDX;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_PRIME;
          prime_cnt_d  = '0;
          last_grant_d = LAST_IDX;
          underflow_d  = 1'b0;
        end
        ST_PRIME: begin
          if (transfer) begin
            if (prime_cnt_q == LAST_IDX) begin
              state_d      = ST_RUN;
              last_grant_d = LAST_IDX;
            end else begin
              prime_cnt_d = prime_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (transfer) begin
            last_grant_d = rr_idx;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ssm_go_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      prime_cnt_q  <= '0;
      last_grant_q <= LAST_IDX;
      underflow_q  <= 1'b0;
      ssm_go_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prime_cnt_q  <= prime_cnt_d;
      last_grant_q <= last_grant_d;
      underflow_q  <= underflow_d;
      ssm_go_q     <= ssm_go_d;
    end
  end

  for (genvar k = 0; k < NUM_SSM; k++) begin : g_buf
    ssm_word_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (BUF_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (!start_dec),
      .push      (push_v[k]),
      .push_data (in_data),
      .pop       (pop_v[k]),
      .head      (ssm_data[k*WORD_W +: WORD_W]),
      .count     (cnt[k]),
      .empty     (empty_v[k])
    );
  end

  assign ssm_empty     = empty_v;
  assign ssm_go        = ssm_go_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_ssm_demux_sched.sv
// tb/tb_ssm_demux_sched.sv - directed self-checking bench for ssm_demux_sched
module tb_ssm_demux_sched;

  localparam int NUM_SSM   = 4;
  localparam int WORD_W    = 128;
  localparam int BUF_DEPTH = 2;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic                      start_dec;
  logic                      in_valid;
  logic [WORD_W-1:0]         in_data;
  logic                      in_ready;
  logic [NUM_SSM-1:0]        ssm_rd_en;
  logic [NUM_SSM*WORD_W-1:0] ssm_data;
  logic [NUM_SSM-1:0]        ssm_empty;
  logic                      ssm_go;
  logic                      underflow_err;

  int n_chk = 0;
  int n_err = 0;
  logic [NUM_SSM-1:0] exp_e;

  always #5 clk = ~clk;

  ssm_demux_sched #(
    .NUM_SSM   (NUM_SSM),
    .WORD_W    (WORD_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_dec     (start_dec),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .ssm_rd_en     (ssm_rd_en),
    .ssm_data      (ssm_data),
    .ssm_empty     (ssm_empty),
    .ssm_go        (ssm_go),
    .underflow_err (underflow_err)
  );

  task automatic chk(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] head(input int k);
    return ssm_data[k*WORD_W +: WORD_W];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_go"}, ssm_go, 0);
    chk({pfx, "_empty"}, ssm_empty, 4'hF);
    chk({pfx, "_underflow"}, underflow_err, 0);
    for (int k = 0; k < NUM_SSM; k++) chk($sformatf("%s_data%0d", pfx, k), head(k), 0);
  endtask

  initial begin
    rstn = 1'b0; start_dec = 1'b0; in_valid = 1'b0; in_data = '0; ssm_rd_en = '0;
    tick(); tick();
    chk_reset_vals("rst");

    // pops in IDLE are ignored
    rstn = 1'b1; ssm_rd_en = 4'hF;
    tick();
    chk("idle_pop", underflow_err, 0);
    ssm_rd_en = '0;

    // prime: A0..A3 go to substreams 0..3
    start_dec = 1'b1; in_valid = 1'b1; in_data = 128'hA0;
    #1 chk("idle_rdy", in_ready, 0);
    tick();
    for (int i = 0; i < NUM_SSM; i++) begin
      in_data = 128'hA0 + i;
      #1 chk($sformatf("prime_rdy%0d", i), in_ready, 1);
      chk($sformatf("prime_go%0d", i), ssm_go, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("prime_go_up", ssm_go, 1);
    chk("prime_empty", ssm_empty, 4'h0);
    for (int k = 0; k < NUM_SSM; k++) chk($sformatf("prime_head%0d", k), head(k), 128'hA0 + k);

    // round robin with one pop per cycle on the substream holding data
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 128'hB0 + i;
      ssm_rd_en = (i == 0) ? 4'hF : (4'b0001 << ((i - 1) % 4));
      #1 chk($sformatf("rr_rdy%0d", i), in_ready, 1);
      tick();
      exp_e = ~(4'b0001 << (i % 4));
      chk($sformatf("rr_empty%0d", i), ssm_empty, exp_e);
      chk($sformatf("rr_head%0d", i), head(i % 4), 128'hB0 + i);
    end
    in_valid = 1'b0; ssm_rd_en = 4'b1000;
    tick();
    ssm_rd_en = '0;
    chk("rr_drained", ssm_empty, 4'hF);
    chk("rr_no_uf", underflow_err, 0);

    // fill every buffer to depth, then free one slot on substream 2
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 128'hC0 + i;
      tick();
    end
    in_data = 128'hC8;
    #1 chk("full_rdy", in_ready, 0);
    ssm_rd_en = 4'b0100;
    #1 chk("full_pop_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0; ssm_rd_en = '0;
    #1 chk("refull_rdy", in_ready, 0);
    chk("full_s2_head", head(2), 128'hC6);
    chk("full_s0_head", head(0), 128'hC0);
    ssm_rd_en = 4'b0100;
    tick();
    ssm_rd_en = '0;
    chk("full_s2_next", head(2), 128'hC8);

    // underflow on substream 1
    chk("uf_s1_head", head(1), 128'hC1);
    ssm_rd_en = 4'b0010;
    tick();
    chk("uf_s1_next", head(1), 128'hC5);
    tick();
    chk("uf_s1_empty", ssm_empty, 4'b0010);
    chk("uf_before", underflow_err, 0);
    tick();
    ssm_rd_en = '0;
    chk("uf_set", underflow_err, 1);
    chk("uf_state_kept", ssm_empty, 4'b0010);
    tick();
    chk("uf_sticky", underflow_err, 1);

    // RR skips full buffers: D0 -> s1, D1 -> s2; then drain s3
    in_valid = 1'b1; in_data = 128'hD0;
    tick();
    in_data = 128'hD1;
    tick();
    in_valid = 1'b0;
    chk("skip_s1", head(1), 128'hD0);
    chk("skip_s2", head(2), 128'hC8);
    chk("skip_s3", head(3), 128'hC3);
    ssm_rd_en = 4'b1000;
    tick();
    chk("drain_s3", head(3), 128'hC7);
    tick();
    ssm_rd_en = '0;
    chk("drain_empty", ssm_empty, 4'b1000);

    // abort with counts 2,1,2,0
    start_dec = 1'b0; in_valid = 1'b1; in_data = 128'hE0;
    #1 chk("abort_rdy", in_ready, 0);
    tick();
    in_valid = 1'b0;
    chk("abort_empty", ssm_empty, 4'hF);
    chk("abort_go", ssm_go, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_data0", head(0), 0);
    chk("abort_uf_sticky", underflow_err, 1);

    // new slice clears underflow
    start_dec = 1'b1;
    tick();
    chk("slice_uf_clr", underflow_err, 0);
    #1 chk("slice_prime_rdy", in_ready, 1);

    // reset mid-prime after two words
    in_valid = 1'b1; in_data = 128'hF0;
    tick();
    in_data = 128'hF1;
    tick();
    chk("midprime_s1", head(1), 128'hF1);
    in_data = 128'hF2;
    #2 rstn = 1'b0;
    #1 chk_reset_vals("mid_rst");
    tick();
    rstn = 1'b1; in_data = 128'h60;
    tick();
    tick();
    in_valid = 1'b0;
    chk("restart_s0", head(0), 128'h60);
    chk("restart_empty", ssm_empty, 4'b1110);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
